// File: rtl/serdes_pattern_chk.sv
// Soft pattern generator and self-synchronising checker for SERDES loopback bring-up.
// PRBS-7/15/31, byte counter and comma on TX; HUNT/LOCKED checker with saturating counters on RX.
//
//   state  | meaning
//   HUNT   | searching: counting consecutive error-free words toward lock
//   LOCKED | aligned: words are counted, consecutive errored words drop lock
module serdes_pattern_chk #(
  parameter int W          = 16,
  parameter int ERR_CNT_W  = 16,
  parameter int WORD_CNT_W = 32,
  parameter int LOCK_GOOD  = 16,
  parameter int LOCK_BAD   = 4
) (
  input  logic                  ref_clk,
  input  logic                  rst,
  input  logic [2:0]            mode_i,
  input  logic                  force_err_i,
  input  logic                  cnt_clr_i,
  output logic [W-1:0]          tx_data_o,
  output logic [W/8-1:0]        tx_k_o,
  input  logic [W-1:0]          rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o
);

  localparam int NB     = W / 8;
  localparam int NERR_W = $clog2(W + 1);
  localparam int SUM_W  = ((ERR_CNT_W > NERR_W) ? ERR_CNT_W : NERR_W) + 1;
  localparam int GOOD_W = (LOCK_GOOD > 1) ? $clog2(LOCK_GOOD) : 1;
  localparam int BAD_W  = (LOCK_BAD > 1) ? $clog2(LOCK_BAD) : 1;

  localparam logic [GOOD_W-1:0] GOOD_RLD = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [BAD_W-1:0]  BAD_RLD  = BAD_W'(LOCK_BAD - 1);

  localparam logic [2:0] M_OFF   = 3'd0;
  localparam logic [2:0] M_P7    = 3'd1;
  localparam logic [2:0] M_P15   = 3'd2;
  localparam logic [2:0] M_P31   = 3'd3;
  localparam logic [2:0] M_CNT   = 3'd4;
  localparam logic [2:0] M_COMMA = 3'd5;

  typedef enum logic {HUNT, LOCKED} state_t;

  // History bit s[0] is the most recent serial bit, s[k] is k+1 bits back.
  function automatic logic prbs_tap(input logic [30:0] s, input logic [2:0] m);
    case (m)
      M_P7:    return s[6] ^ s[5];
      M_P15:   return s[14] ^ s[13];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  // Runs W serial steps. With sync set the history is fed from the line
  // (self-synchronising checker), otherwise from the generated bits.
  function automatic logic [W+30:0] prbs_run(input logic [30:0] seed,
                                             input logic [2:0]  m,
                                             input logic [W-1:0] line,
                                             input logic         sync);
    logic [30:0]  s;
    logic [W-1:0] w;
    logic         b;
    s = seed;
    w = '0;
    for (int j = 0; j < W; j++) begin
      b    = prbs_tap(s, m);
      w[j] = b;
      s    = {s[29:0], sync ? line[j] : b};
    end
    return {s, w};
  endfunction

  logic [2:0]  mode_n;
  logic [2:0]  mode_q;
  logic        mode_chg;
  logic        chk_active;

  assign mode_n     = (mode_i > M_COMMA) ? M_OFF : mode_i;
  assign mode_chg   = (mode_n != mode_q);
  assign chk_active = (mode_n >= M_P7) && (mode_n <= M_CNT);

  // ---------------------------------------------------------------- TX path
  logic [30:0]   lfsr_q;
  logic [30:0]   lfsr_cur;
  logic [30:0]   lfsr_nxt;
  logic [W-1:0]  gen_word;
  logic [7:0]    base_q;
  logic [7:0]    base_cur;
  logic [W-1:0]  cnt_word;
  logic [W-1:0]  tx_word;
  logic [NB-1:0] tx_k;

  assign lfsr_cur = mode_chg ? '1 : lfsr_q;
  assign base_cur = mode_chg ? 8'd0 : base_q;
  assign {lfsr_nxt, gen_word} = prbs_run(lfsr_cur, mode_n, {W{1'b0}}, 1'b0);

  always_comb begin
    cnt_word = '0;
    for (int k = 0; k < NB; k++) begin
      cnt_word[8*k +: 8] = base_cur + 8'(k);
    end
  end

  always_comb begin
    tx_word = '0;
    tx_k    = '0;
    case (mode_n)
      M_P7, M_P15, M_P31: tx_word = gen_word;
      M_CNT:              tx_word = cnt_word;
      M_COMMA: begin
        for (int k = 0; k < NB; k++) begin
          tx_word[8*k +: 8] = (k == 0) ? 8'hBC : 8'h4A;
        end
        tx_k[0] = 1'b1;
      end
      default: tx_word = '0;
    endcase
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      mode_q    <= M_OFF;
      lfsr_q    <= '1;
      base_q    <= 8'd0;
      tx_data_o <= '0;
      tx_k_o    <= '0;
    end else begin
      mode_q    <= mode_n;
      lfsr_q    <= lfsr_nxt;
      base_q    <= base_cur + 8'(NB);
      tx_data_o <= tx_word ^ {{(W-1){1'b0}}, force_err_i};
      tx_k_o    <= tx_k;
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [30:0]       hist_q;
  logic [30:0]       hist_nxt;
  logic [W-1:0]      prbs_exp;
  logic [7:0]        prev_byte_q;
  logic [W-1:0]      cnt_exp;
  logic [W-1:0]      exp_word;
  logic [NERR_W-1:0] nerr;
  logic              word_err;
  logic              check;

  assign {hist_nxt, prbs_exp} = prbs_run(hist_q, mode_n, rx_data_i, 1'b1);

  always_comb begin
    cnt_exp      = '0;
    cnt_exp[7:0] = prev_byte_q + 8'd1;
    for (int k = 1; k < NB; k++) begin
      cnt_exp[8*k +: 8] = rx_data_i[8*(k-1) +: 8] + 8'd1;
    end
  end

  assign exp_word = (mode_n == M_CNT) ? cnt_exp : prbs_exp;
  assign nerr     = NERR_W'($countones(exp_word ^ rx_data_i));
  assign word_err = (nerr != '0);
  assign check    = rx_valid_i && chk_active && !mode_chg;

  // ---------------------------------------------------------------- lock FSM
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      good_q  <= GOOD_RLD;
      bad_q   <= BAD_RLD;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Run lengths are down-counters; terminal count zero means this word completes the run.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (mode_chg || !chk_active) begin
      state_d = HUNT;
      good_d  = GOOD_RLD;
      bad_d   = BAD_RLD;
    end else if (rx_valid_i) begin
      if (!word_err) begin
        bad_d = BAD_RLD;
        if (state_q == HUNT) begin
          if (good_q == '0) begin
            state_d = LOCKED;
            good_d  = GOOD_RLD;
          end else begin
            good_d = good_q - 1'b1;
          end
        end
      end else begin
        good_d = GOOD_RLD;
        if (state_q == LOCKED) begin
          if (bad_q == '0) begin
            state_d = HUNT;
            bad_d   = BAD_RLD;
          end else begin
            bad_d = bad_q - 1'b1;
          end
        end
      end
    end
  end

  assign locked_o = (state_q == LOCKED);

  // ---------------------------------------------------------------- history and counters
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_CNT_W-1:0] err_sat;

  assign err_sum = SUM_W'(err_cnt_o) + SUM_W'(nerr);
  assign err_sat = (err_sum > SUM_W'({ERR_CNT_W{1'b1}})) ? {ERR_CNT_W{1'b1}}
                                                          : err_sum[ERR_CNT_W-1:0];

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      prev_byte_q <= 8'd0;
      err_o       <= 1'b0;
    end else begin
      err_o <= check && word_err;
      if (mode_chg) begin
        hist_q      <= '0;
        prev_byte_q <= 8'd0;
      end else if (check) begin
        hist_q      <= hist_nxt;
        prev_byte_q <= rx_data_i[W-1 -: 8];
      end
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      err_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else if (check && (state_q == LOCKED)) begin
      err_cnt_o <= err_sat;
      if (word_cnt_o != {WORD_CNT_W{1'b1}}) begin
        word_cnt_o <= word_cnt_o + WORD_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serdes_pattern_chk.sv
// Directed/random bench for serdes_pattern_chk with a serial-stream reference model.
// Every cycle the DUT outputs are compared against the model; key spec points get explicit checks.
module tb_serdes_pattern_chk;

  localparam int W   = 32;
  localparam int NB  = W / 8;
  localparam int ECW = 4;
  localparam int WCW = 8;
  localparam int LG  = 16;
  localparam int LB  = 4;

  logic           ref_clk = 1'b0;
  logic           rst;
  logic [2:0]     mode_i;
  logic           force_err_i;
  logic           cnt_clr_i;
  logic [W-1:0]   tx_data_o;
  logic [NB-1:0]  tx_k_o;
  logic [W-1:0]   rx_data_i;
  logic           rx_valid_i;
  logic           locked_o;
  logic           err_o;
  logic [ECW-1:0] err_cnt_o;
  logic [WCW-1:0] word_cnt_o;

  serdes_pattern_chk #(
    .W(W), .ERR_CNT_W(ECW), .WORD_CNT_W(WCW), .LOCK_GOOD(LG), .LOCK_BAD(LB)
  ) dut (
    .ref_clk(ref_clk), .rst(rst), .mode_i(mode_i), .force_err_i(force_err_i),
    .cnt_clr_i(cnt_clr_i), .tx_data_o(tx_data_o), .tx_k_o(tx_k_o),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .locked_o(locked_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .word_cnt_o(word_cnt_o)
  );

  always #5 ref_clk = ~ref_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: serial bit streams kept as queues, newest bit at the back
  int            m_prev_mode;
  bit            tx_q[$];
  int            m_base;
  logic [W-1:0]  m_tx;
  logic [NB-1:0] m_k;
  bit            rx_q[$];
  int            m_prev_byte;
  bit            m_locked;
  int            good_run;
  int            bad_run;
  bit            m_err;
  int            m_ecnt;
  int            m_wcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int norm(input logic [2:0] m);
    return (m > 3'd5) ? 0 : int'(m);
  endfunction

  function automatic int lag_a(input int m);
    return (m == 1) ? 7 : (m == 2) ? 15 : 31;
  endfunction

  function automatic int lag_b(input int m);
    return (m == 1) ? 6 : (m == 2) ? 14 : 28;
  endfunction

  task automatic model_reset();
    m_prev_mode = 0;
    tx_q = {};
    repeat (31) tx_q.push_back(1'b1);
    rx_q = {};
    repeat (31) rx_q.push_back(1'b0);
    m_base = 0; m_tx = '0; m_k = '0;
    m_prev_byte = 0; m_locked = 0; good_run = 0; bad_run = 0;
    m_err = 0; m_ecnt = 0; m_wcnt = 0;
  endtask

  task automatic model_update();
    int           nm;
    bit           chg;
    bit           b;
    int           nerr;
    logic [W-1:0] w;
    logic [W-1:0] e;
    logic [NB-1:0] k;
    nm  = norm(mode_i);
    chg = (nm != m_prev_mode);
    w = '0; k = '0; e = '0;
    if (chg) begin
      tx_q = {};
      repeat (31) tx_q.push_back(1'b1);
      m_base = 0;
    end
    if (nm >= 1 && nm <= 3) begin
      for (int j = 0; j < W; j++) begin
        b = tx_q[tx_q.size() - lag_a(nm)] ^ tx_q[tx_q.size() - lag_b(nm)];
        w[j] = b;
        tx_q.push_back(b);
        void'(tx_q.pop_front());
      end
    end else if (nm == 4) begin
      for (int kk = 0; kk < NB; kk++) w[8*kk +: 8] = 8'((m_base + kk) % 256);
    end else if (nm == 5) begin
      for (int kk = 0; kk < NB; kk++) w[8*kk +: 8] = (kk == 0) ? 8'hBC : 8'h4A;
      k[0] = 1'b1;
    end
    m_base = (m_base + NB) % 256;
    w[0] = w[0] ^ force_err_i;
    m_tx = w;
    m_k  = k;

    if (chg) begin
      rx_q = {};
      repeat (31) rx_q.push_back(1'b0);
      m_prev_byte = 0; m_locked = 0; good_run = 0; bad_run = 0; m_err = 0;
    end else if (nm < 1 || nm > 4) begin
      m_locked = 0; good_run = 0; bad_run = 0; m_err = 0;
    end else if (!rx_valid_i) begin
      m_err = 0;
    end else begin
      if (nm == 4) begin
        e[7:0] = 8'(m_prev_byte + 1);
        for (int kk = 1; kk < NB; kk++) e[8*kk +: 8] = rx_data_i[8*(kk-1) +: 8] + 8'd1;
        m_prev_byte = int'(rx_data_i[W-1 -: 8]);
      end else begin
        for (int j = 0; j < W; j++) begin
          e[j] = rx_q[rx_q.size() - lag_a(nm)] ^ rx_q[rx_q.size() - lag_b(nm)];
          rx_q.push_back(bit'(rx_data_i[j]));
          void'(rx_q.pop_front());
        end
      end
      nerr = $countones(e ^ rx_data_i);
      if (m_locked) begin
        m_ecnt = (m_ecnt + nerr > 15) ? 15 : m_ecnt + nerr;
        m_wcnt = (m_wcnt + 1 > 255) ? 255 : m_wcnt + 1;
      end
      if (nerr == 0) begin
        good_run++;
        bad_run = 0;
        if (!m_locked && good_run >= LG) begin m_locked = 1; good_run = 0; end
      end else begin
        bad_run++;
        good_run = 0;
        if (m_locked && bad_run >= LB) begin m_locked = 0; bad_run = 0; end
      end
      m_err = (nerr != 0);
    end
    if (cnt_clr_i) begin m_ecnt = 0; m_wcnt = 0; end
    m_prev_mode = nm;
  endtask

  task automatic check_all();
    chk("tx_data",  64'(tx_data_o),  64'(m_tx));
    chk("tx_k",     64'(tx_k_o),     64'(m_k));
    chk("locked",   64'(locked_o),   64'(m_locked));
    chk("err",      64'(err_o),      64'(m_err));
    chk("err_cnt",  64'(err_cnt_o),  64'(m_ecnt));
    chk("word_cnt", 64'(word_cnt_o), 64'(m_wcnt));
  endtask

  task automatic tick();
    @(posedge ref_clk);
    model_update();
    @(negedge ref_clk);
    check_all();
  endtask

  // n cycles with the model's TX word looped back as the next RX word
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx_data_i = m_tx;
    end
  endtask

  task automatic clr_pulse();
    cnt_clr_i = 1'b1;
    run(1);
    cnt_clr_i = 1'b0;
  endtask

  initial begin
    int           exp_e;
    int           saved;
    logic [7:0]   b2;
    logic [7:0]   b3;
    rst = 1'b1; mode_i = 3'd1; force_err_i = 1'b0; cnt_clr_i = 1'b0;
    rx_data_i = '0; rx_valid_i = 1'b1;
    model_reset();
    repeat (2) @(negedge ref_clk);
    chk("rst_tx_data",  64'(tx_data_o),  64'd0);
    chk("rst_tx_k",     64'(tx_k_o),     64'd0);
    chk("rst_locked",   64'(locked_o),   64'd0);
    chk("rst_err_cnt",  64'(err_cnt_o),  64'd0);
    chk("rst_word_cnt", 64'(word_cnt_o), 64'd0);
    rst = 1'b0;

    // PRBS-7 loopback: lock within 20 cycles, then run into word counter saturation
    for (int i = 0; i < 20 && !locked_o; i++) run(1);
    chk("p7_lock_by_20", 64'(locked_o), 64'd1);
    run(300);
    chk("p7_no_errors", 64'(err_cnt_o), 64'd0);
    chk("word_cnt_sat", 64'(word_cnt_o), 64'hFF);
    clr_pulse();
    chk("clr_word_cnt", 64'(word_cnt_o), 64'd0);
    run(3);
    chk("word_cnt_step", 64'(word_cnt_o), 64'd3);

    force_err_i = 1'b1;
    run(1);
    force_err_i = 1'b0;
    run(4);
    chk("p7_force_err3", 64'(err_cnt_o), 64'd3);
    chk("p7_still_locked", 64'(locked_o), 64'd1);

    // PRBS-31
    mode_i = 3'd3;
    run(1);
    chk("p31_chg_unlock", 64'(locked_o), 64'd0);
    run(25);
    chk("p31_locked", 64'(locked_o), 64'd1);
    clr_pulse();
    force_err_i = 1'b1;
    run(1);
    force_err_i = 1'b0;
    run(5);
    chk("p31_force_err3", 64'(err_cnt_o), 64'd3);
    chk("p31_still_locked", 64'(locked_o), 64'd1);

    // rx_valid gaps with garbage data
    rx_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data_i = W'($urandom);
      tick();
    end
    rx_valid_i = 1'b1;
    rx_data_i = m_tx;
    run(6);

    // PRBS-15 with random line data: saturation and loss of lock
    mode_i = 3'd2;
    run(25);
    chk("p15_locked", 64'(locked_o), 64'd1);
    clr_pulse();
    for (int i = 0; i < LB; i++) begin
      rx_data_i = W'($urandom);
      tick();
    end
    chk("p15_unlock_after_bad", 64'(locked_o), 64'd0);
    chk("err_cnt_sat", 64'(err_cnt_o), 64'hF);
    for (int i = 0; i < 3; i++) begin
      rx_data_i = W'($urandom);
      tick();
    end
    chk("err_cnt_hold_hunt", 64'(err_cnt_o), 64'hF);
    rx_data_i = m_tx;

    // byte counter
    mode_i = 3'd4;
    run(1);
    chk("cnt_word0", 64'(tx_data_o), 64'h03020100);
    run(1);
    chk("cnt_word1", 64'(tx_data_o), 64'h07060504);
    run(25);
    chk("cnt_locked", 64'(locked_o), 64'd1);
    clr_pulse();
    chk("cnt_no_errors", 64'(err_cnt_o), 64'd0);
    b2 = m_tx[23:16];
    b3 = m_tx[31:24];
    exp_e = $countones(b2) + $countones(b3 ^ 8'h01);
    if (exp_e > 15) exp_e = 15;
    rx_data_i = m_tx & 32'hFF00FFFF;
    tick();
    rx_data_i = m_tx;
    run(3);
    chk("cnt_byte2_drop", 64'(err_cnt_o), 64'(exp_e));
    chk("cnt_still_locked", 64'(locked_o), 64'd1);

    // comma and reserved modes
    saved = m_ecnt;
    mode_i = 3'd5;
    run(1);
    chk("comma_data", 64'(tx_data_o), 64'h4A4A4ABC);
    chk("comma_k", 64'(tx_k_o), 64'h1);
    chk("comma_unlocked", 64'(locked_o), 64'd0);
    run(5);
    chk("comma_data_hold", 64'(tx_data_o), 64'h4A4A4ABC);
    chk("comma_err_cnt_hold", 64'(err_cnt_o), 64'(saved));
    mode_i = 3'd7;
    run(2);
    chk("mode7_off", 64'(tx_data_o), 64'd0);

    // clear together with an errored word, then mode change relock
    mode_i = 3'd1;
    run(25);
    run(5);
    rx_data_i = m_tx ^ 32'h1;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    rx_data_i = m_tx;
    chk("clr_prio_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("clr_prio_word_cnt", 64'(word_cnt_o), 64'd0);
    chk("clr_prio_err_flag", 64'(err_o), 64'd1);
    mode_i = 3'd2;
    run(1);
    chk("chg12_unlock", 64'(locked_o), 64'd0);
    run(25);
    chk("chg12_relock", 64'(locked_o), 64'd1);

    // asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_data", 64'(tx_data_o), 64'd0);
    chk("arst_locked", 64'(locked_o), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("arst_word_cnt", 64'(word_cnt_o), 64'd0);
    model_reset();
    rx_data_i = '0;
    mode_i = 3'd1;
    @(negedge ref_clk);
    rst = 1'b0;
    run(25);
    chk("arst_relock", 64'(locked_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
